// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline adaptor between the I-cache
// and D-cache; one line transaction in flight at a time.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_address_i,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_address_i,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [LINE_W-1:0] mem_line_o,
    input  logic [LINE_W-1:0] mem_line_i,
    input  logic              mem_resp_i
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(LINE_W / 8 - 1);

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wline_q, wline_d;

    logic i_pend;
    logic d_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wline_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wline_q  <= wline_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d_d      = last_d_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        wline_d       = wline_q;
        i_pend        = i_read_i;
        // read and write together is malformed; treat D as idle
        d_pend        = d_read_i ^ d_write_i;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        mem_address_o = '0;
        mem_line_o    = '0;
        i_resp_o      = 1'b0;
        i_line_o      = '0;
        d_resp_o      = 1'b0;
        d_line_o      = '0;

        unique case (state_q)
            IDLE: begin
                if (d_pend && (!i_pend || !last_d_q)) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = d_address_i;
                    wr_d     = d_write_i;
                    wline_d  = d_write_i ? d_line_i : '0;
                end else if (i_pend) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = i_address_i;
                    wr_d     = 1'b0;
                    wline_d  = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                mem_read_o    = !wr_q;
                mem_write_o   = wr_q;
                mem_address_o = addr_q & ALIGN;
                mem_line_o    = wr_q ? wline_q : '0;
                if (mem_resp_i) begin
                    state_d = IDLE;
                    if (state_q == SERVE_I) begin
                        i_resp_o = 1'b1;
                        i_line_o = wr_q ? '0 : mem_line_i;
                    end else begin
                        d_resp_o = 1'b1;
                        d_line_o = wr_q ? '0 : mem_line_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed-vector bench for cache_arbiter.
module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_read_i;
    logic [ADDR_W-1:0] i_address_i;
    logic [LINE_W-1:0] i_line_o;
    logic              i_resp_o;
    logic              d_read_i;
    logic              d_write_i;
    logic [ADDR_W-1:0] d_address_i;
    logic [LINE_W-1:0] d_line_i;
    logic [LINE_W-1:0] d_line_o;
    logic              d_resp_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_address_o;
    logic [LINE_W-1:0] mem_line_o;
    logic [LINE_W-1:0] mem_line_i;
    logic              mem_resp_i;

    int n_pass = 0;
    int n_chk  = 0;

    localparam logic [LINE_W-1:0] LA = {8{32'hAAAA_AAAA}};
    localparam logic [LINE_W-1:0] LB = {8{32'hBBBB_BBBB}};
    localparam logic [LINE_W-1:0] LC = {8{32'hCCCC_CCCC}};
    localparam logic [LINE_W-1:0] LW = {4{64'h0123_4567_89AB_CDEF}};

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_read_i     (i_read_i),
        .i_address_i  (i_address_i),
        .i_line_o     (i_line_o),
        .i_resp_o     (i_resp_o),
        .d_read_i     (d_read_i),
        .d_write_i    (d_write_i),
        .d_address_i  (d_address_i),
        .d_line_i     (d_line_i),
        .d_line_o     (d_line_o),
        .d_resp_o     (d_resp_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_address_o(mem_address_o),
        .mem_line_o   (mem_line_o),
        .mem_line_i   (mem_line_i),
        .mem_resp_i   (mem_resp_i)
    );

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_read_i   = 1'b0;
        d_read_i   = 1'b0;
        d_write_i  = 1'b0;
        mem_resp_i = 1'b0;
        mem_line_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        settle();
    endtask

    initial begin
        idle_inputs();
        i_address_i = '0;
        d_address_i = '0;
        d_line_i    = '0;
        reset_n     = 1'b0;
        #2;
        check("rst_rd", mem_read_o, 0);
        check("rst_wr", mem_write_o, 0);
        check("rst_addr", mem_address_o, 0);
        check("rst_mline", mem_line_o, 0);
        check("rst_iresp", i_resp_o, 0);
        check("rst_dresp", d_resp_o, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // I read alone
        i_read_i    = 1'b1;
        i_address_i = 32'h0000_1234;
        settle();
        check("i_lat0", mem_read_o, 0);
        tick();
        check("i_rd", mem_read_o, 1);
        check("i_wr", mem_write_o, 0);
        check("i_addr", mem_address_o, 32'h0000_1220);
        for (int k = 0; k < 5; k++) tick();
        check("i_wait", i_resp_o, 0);
        mem_resp_i = 1'b1;
        mem_line_i = LA;
        settle();
        check("i_resp", i_resp_o, 1);
        check("i_line", i_line_o, LA);
        check("i_dresp", d_resp_o, 0);
        check("i_dline", d_line_o, 0);
        tick();
        idle_inputs();
        settle();
        check("i_turn_rd", mem_read_o, 0);
        check("i_turn_resp", i_resp_o, 0);
        tick();

        // D writeback; client inputs change mid-service
        d_write_i   = 1'b1;
        d_address_i = 32'h8000_0040;
        d_line_i    = LW;
        tick();
        check("dw_wr", mem_write_o, 1);
        check("dw_rd", mem_read_o, 0);
        check("dw_addr", mem_address_o, 32'h8000_0040);
        check("dw_line", mem_line_o, LW);
        d_write_i   = 1'b0;
        d_address_i = 32'h1111_1111;
        d_line_i    = LB;
        tick();
        tick();
        check("dw_hold_line", mem_line_o, LW);
        check("dw_hold_addr", mem_address_o, 32'h8000_0040);
        check("dw_hold_wr", mem_write_o, 1);
        mem_resp_i = 1'b1;
        mem_line_i = LC;
        settle();
        check("dw_resp", d_resp_o, 1);
        check("dw_dline", d_line_o, 0);
        check("dw_iresp", i_resp_o, 0);
        tick();
        idle_inputs();
        settle();
        check("dw_after", mem_write_o, 0);
        tick();

        // contention right after reset: D first, then I, then alternate
        do_reset();
        i_read_i    = 1'b1;
        i_address_i = 32'h0000_0100;
        d_read_i    = 1'b1;
        d_address_i = 32'h0000_0200;
        tick();
        check("c1_addr", mem_address_o, 32'h0000_0200);
        check("c1_rd", mem_read_o, 1);
        mem_resp_i = 1'b1;
        mem_line_i = LB;
        settle();
        check("c1_dresp", d_resp_o, 1);
        check("c1_dline", d_line_o, LB);
        check("c1_iresp", i_resp_o, 0);
        check("c1_iline", i_line_o, 0);
        tick();
        d_read_i   = 1'b0;
        mem_resp_i = 1'b0;
        settle();
        check("c1_m1_rd", mem_read_o, 0);
        tick();
        check("c2_m2_rd", mem_read_o, 1);
        check("c2_addr", mem_address_o, 32'h0000_0100);
        d_read_i    = 1'b1;
        d_address_i = 32'h0000_0300;
        tick();
        mem_resp_i = 1'b1;
        mem_line_i = LC;
        settle();
        check("c2_iresp", i_resp_o, 1);
        check("c2_iline", i_line_o, LC);
        check("c2_dresp", d_resp_o, 0);
        tick();
        i_read_i   = 1'b0;
        mem_resp_i = 1'b0;
        settle();
        check("c2_m1_rd", mem_read_o, 0);
        tick();
        check("c3_addr", mem_address_o, 32'h0000_0300);
        mem_resp_i = 1'b1;
        settle();
        check("c3_dresp", d_resp_o, 1);
        tick();
        idle_inputs();
        tick();
        i_read_i = 1'b1;
        d_read_i = 1'b1;
        tick();
        check("c4_tie_i", mem_address_o, 32'h0000_0100);
        mem_resp_i = 1'b1;
        settle();
        check("c4_iresp", i_resp_o, 1);
        tick();
        idle_inputs();
        tick();

        // illegal D request is not pending
        d_read_i  = 1'b1;
        d_write_i = 1'b1;
        tick();
        tick();
        check("ill_rd", mem_read_o, 0);
        check("ill_wr", mem_write_o, 0);
        i_read_i    = 1'b1;
        i_address_i = 32'h0000_0440;
        tick();
        check("ill_igrant", mem_read_o, 1);
        check("ill_iaddr", mem_address_o, 32'h0000_0440);
        mem_resp_i = 1'b1;
        settle();
        check("ill_iresp", i_resp_o, 1);
        tick();
        idle_inputs();
        tick();

        // async reset mid SERVE_D, then tie goes to D
        d_read_i    = 1'b1;
        d_address_i = 32'h0000_0200;
        tick();
        check("rs_rd", mem_read_o, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rs_rd0", mem_read_o, 0);
        check("rs_addr0", mem_address_o, 0);
        idle_inputs();
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        check("rs_idle", mem_read_o, 0);
        i_read_i = 1'b1;
        d_read_i = 1'b1;
        tick();
        check("rs_tie_d", mem_address_o, 32'h0000_0200);
        mem_resp_i = 1'b1;
        settle();
        check("rs_dresp", d_resp_o, 1);
        tick();
        idle_inputs();
        tick();

        // stray adaptor response in IDLE
        mem_resp_i = 1'b1;
        mem_line_i = LA;
        settle();
        check("stray_i", i_resp_o, 0);
        check("stray_d", d_resp_o, 0);
        check("stray_iline", i_line_o, 0);
        tick();
        mem_resp_i = 1'b0;
        settle();
        check("stray_rd", mem_read_o, 0);
        check("stray_wr", mem_write_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-client line-request arbiter between the instruction cache and data cache and the single cacheline adaptor that bursts to DRAM. Accepts 256-bit line reads from the I-cache and line reads/writebacks from the D-cache. Grants one request at a time with round-robin fairness and presents it on the adaptor's LLC-side read/write/address/line interface. Returns the adaptor's response pulse and read line to the granted client only.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cache line width; line offset bits = log2(LINE_W/8) = 5

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- i_read_i  in  1  I-cache line read request, level, held until i_resp_o
- i_address_i  in  ADDR_W  I-cache request address
- i_line_o  out  LINE_W  read line to I-cache, valid only while i_resp_o=1
- i_resp_o  out  1  one-cycle completion pulse to I-cache
- d_read_i  in  1  D-cache line read request, level
- d_write_i  in  1  D-cache writeback request, level
- d_address_i  in  ADDR_W  D-cache request address
- d_line_i  in  LINE_W  D-cache writeback data
- d_line_o  out  LINE_W  read line to D-cache, valid only while d_resp_o=1
- d_resp_o  out  1  one-cycle completion pulse to D-cache
- mem_read_o  out  1  read request to adaptor
- mem_write_o  out  1  write request to adaptor
- mem_address_o  out  ADDR_W  line-aligned address to adaptor
- mem_line_o  out  LINE_W  writeback line to adaptor
- mem_line_i  in  LINE_W  read line from adaptor
- mem_resp_i  in  1  one-cycle completion pulse from adaptor

## Operation
- Pending: I pending = i_read_i. D pending = d_read_i XOR d_write_i. A D request with both read and write high is illegal and is treated as not pending.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Only I pending -> SERVE_I.
  - Only D pending -> SERVE_D.
  - Both pending -> grant the client not recorded in last_grant.
  - On any grant, capture into registers: address, op (read/write), write line (D writes only). Update last_grant.
- SERVE_x:
  - Drive mem_read_o or mem_write_o from the latched op.
  - mem_address_o = {latched_addr[ADDR_W-1:5], 5'b0}.
  - mem_line_o = latched write line for writes; 0 otherwise.
  - On mem_resp_i=1: assert x_resp_o combinationally in the same cycle. Drive x_line_o = mem_line_i for reads (0 for writes). Next state IDLE.
- Non-granted client: resp 0, line 0.
- mem_read_o and mem_write_o are never both 1, and both are 0 in IDLE.
- Client dropping its request mid-service: ignored. The transaction completes from the latched values and the resp pulse is still delivered.
- mem_resp_i in IDLE: ignored; no client resp.
- Reset (asynchronous, any state):
  - state=IDLE, last_grant=I (D wins the first tie).
  - Latched address/op/line = 0.
  - All outputs 0: mem_read_o, mem_write_o, mem_address_o, mem_line_o, i_resp_o, d_resp_o, i_line_o, d_line_o.

## Timing
- Grant latency: request first high in IDLE at cycle N -> mem_read_o/mem_write_o high from cycle N+1.
- Response: x_resp_o is mem_resp_i gated by grant, with zero added latency.
- Turnaround: after resp, the arbiter spends at least one cycle in IDLE with mem requests low. This lets the adaptor return to its idle state before the next request.
- Back-to-back: resp at cycle M, other client pending -> its request is asserted on mem at cycle M+2.
- Clients must drop their request the cycle after resp. A request still high in IDLE is treated as a new request.
- Latched address and line stay stable on mem outputs for the whole SERVE state, independent of client inputs.

## Test plan
- I read alone: i_read_i=1, addr 0x0000_1234. Adaptor returns resp after 6 cycles with line 0xAA..AA. Required: mem_address_o=0x0000_1220 from the next cycle; i_resp_o=1 for one cycle with i_line_o=0xAA..AA; d_resp_o stays 0.
- D writeback: d_write_i=1, addr 0x8000_0040, d_line_i=0x0123..EF. Required: mem_write_o=1, mem_line_o=0x0123..EF held until resp; d_resp_o pulse; mem_write_o=0 the cycle after.
- Simultaneous I and D reads right after reset. Required: D served first. I is asserted on mem exactly 2 cycles after D's resp and served second. Continued contention alternates I/D.
- Illegal D request: d_read_i=d_write_i=1 with I idle. Required: no mem request issued; stays IDLE. Asserting i_read_i still grants I.
- Reset mid-SERVE_D: reset_n low while mem_read_o=1. Required: all outputs 0 immediately without waiting for clk, state IDLE. After release, a tie grants D.
- Stray mem_resp_i in IDLE: required: i_resp_o=d_resp_o=0, no state change.
